subleq_loader: RTL and testbench
================================

Name: subleq_loader

Overview:
- Boot-time program loader upstream of the subleq core.
- Accepts a byte stream on a valid/ready interface, packs bytes into words, and writes them into the core's dual-port program memory through port 1 (add1/dataIn1/write1).
- Verifies a checksum over the payload, then asserts cpu_run to release the core.
- The core is held while cpu_run=0; the memory port mux is owned by the top level.

Parameters:
- WORD_SIZE, gc::WORD_SIZE, memory word width in bits; must be a multiple of 8 (elaboration error otherwise).
- MEM_SIZE, gc::MEM_SIZE, number of memory words; sets the maximum load length.
- ADDR_W, $clog2(MEM_SIZE), width of the word address.

Ports:
- clk  in  1  system clock; all state updates on posedge clk.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle; transfer = in_valid & in_ready.
- restart  in  1  single-cycle pulse; re-arms the loader from DONE or ERROR.
- mem_add  out  WORD_SIZE  word address to memory port 1, zero-extended from ADDR_W.
- mem_data_in  out  WORD_SIZE  assembled word.
- mem_write  out  1  write strobe, one cycle per word.
- cpu_run  out  1  program loaded and checksum good; core may execute from pc=0.
- load_err  out  1  sticky error flag.
- words_loaded  out  ADDR_W+1  count of words written.

Behaviour:
- Reset values: state=LEN0, in_ready=0, mem_write=0, mem_add=0, mem_data_in=0, cpu_run=0, load_err=0, words_loaded=0, checksum=0. in_ready rises on the first clock after reset release.
- Frame format:
  - LEN_LO, LEN_HI: word count N, 16-bit little-endian.
  - N×BPW payload bytes, where BPW=WORD_SIZE/8. Each word is sent little-endian; byte 0 goes to bits [7:0].
  - CSUM: one byte, equal to the XOR of all payload bytes.
- States: LEN0, LEN1, DATA, CSUM, DONE, ERROR.
  - in_ready=1 in LEN0, LEN1, DATA and CSUM; 0 in DONE and ERROR.
  - LEN0: on transfer, latch len[7:0] and go to LEN1.
  - LEN1: on transfer, latch len[15:8]. If N>MEM_SIZE, go to ERROR. If N=0, go to CSUM. Otherwise go to DATA; clear byte index and word index.
  - DATA: on each transfer, shift the byte into the packer and XOR it into checksum.
    - When byte index = BPW-1, the next cycle drives mem_write=1 for exactly one cycle with mem_add = word index and mem_data_in = the packed word. The word index and words_loaded then increment.
    - After word N-1 completes, go to CSUM.
  - Writes are pipelined: in_ready stays 1 during a write cycle. With WORD_SIZE=8, back-to-back bytes produce back-to-back writes.
  - CSUM: on transfer, compare the byte to the checksum. Match: go to DONE. Mismatch: go to ERROR.
    - The final payload word's write cycle coincides with the CSUM state's first cycle. It must still occur exactly once.
  - DONE: cpu_run=1 (registered, asserted the cycle after the checksum byte). No further writes.
  - ERROR: load_err=1, cpu_run=0.
- restart:
  - In DONE or ERROR: clears cpu_run, load_err, words_loaded and checksum; next state LEN0.
  - In any other state: ignored.
- Stalls: in_valid=0 in any receive state holds all state. No timeout.
- Reset mid-frame: asynchronous return to reset values; a partially loaded memory image is left as-is.
- Address never exceeds MEM_SIZE-1, guaranteed by the LEN1 bound check.
- The length field is wider than ADDR_W. Compare it at full 16 bits; never truncate before the bound check.

Decomposition:
- Shared package: add to gc a loader_state_e enum (LEN0, LEN1, DATA, CSUM, DONE, ERROR), a BYTES_PER_WORD constant, and a LOADER_LEN_W=16 constant.
- Sub-module: word_packer. It handles byte shift-in, byte index counter, word_done pulse and packed word output, and is parameterised by WORD_SIZE.

Test Plan:
- WORD_SIZE=32, frame 02 00 | 11 22 33 44 | 55 66 77 88 | CSUM=0x88 -> writes mem[0]=0x44332211 and mem[1]=0x88776655; cpu_run=1 one cycle after the CSUM transfer; words_loaded=2.
- Same frame with CSUM=0x00 -> both writes occur; load_err=1, cpu_run=0, in_ready=0. restart pulse -> load_err=0, in_ready=1.
- Length 0x0101 with MEM_SIZE=256 -> ERROR right after LEN_HI; no mem_write ever asserted.
- Length 0, CSUM=0x00 -> DONE with no writes, words_loaded=0.
- Random in_valid gaps (30% idle) on the first frame -> identical memory contents; exactly one mem_write per word.
- rst_n low in the middle of word 1 -> all outputs return to reset values immediately. The next full frame loads correctly from address 0.

Source files
------------

// File: rtl/gc.sv
// Global constants and types shared by the subleq core and its boot-time program loader.
package gc;
  localparam int WORD_SIZE      = 32;
  localparam int MEM_SIZE       = 256;
  localparam int BYTES_PER_WORD = WORD_SIZE / 8;
  localparam int LOADER_LEN_W   = 16;

  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_e;
endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer: byte 0 of each word lands in bits [7:0]; a one-cycle
// word_done pulse follows the last byte, with the finished word held on o_word.
module word_packer #(
  parameter int WORD_SIZE = gc::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_shift,
  input  logic [7:0]           i_byte,
  output logic [WORD_SIZE-1:0] o_word,
  output logic                 o_word_done,
  output logic                 o_last
);
  localparam int BPW   = WORD_SIZE / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]     r_idx;
  logic [WORD_SIZE-1:0] r_word;
  logic                 r_done;
  logic [WORD_SIZE-1:0] w_word_nxt;
  logic                 w_last;

  assign w_last = (r_idx == IDX_W'(BPW - 1));

  // Bytes enter at the top and move down, so after BPW shifts the first byte sits at [7:0].
  if (BPW > 1) begin : g_shift
    assign w_word_nxt = {i_byte, r_word[WORD_SIZE-1:8]};
  end else begin : g_single
    assign w_word_nxt = i_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= i_shift & w_last;
      if (i_shift) begin
        r_word <= w_word_nxt;
        r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  assign o_word      = r_word;
  assign o_word_done = r_done;
  assign o_last      = w_last;
endmodule

// File: rtl/subleq_loader.sv
// Boot-time loader: takes a length-prefixed byte frame, writes packed words into program
// memory port 1, and releases the core once the payload XOR checksum matches.
module subleq_loader
  import gc::*;
#(
  parameter int WORD_SIZE = gc::WORD_SIZE,
  parameter int MEM_SIZE  = gc::MEM_SIZE,
  parameter int ADDR_W    = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 restart,
  output logic [WORD_SIZE-1:0] mem_add,
  output logic [WORD_SIZE-1:0] mem_data_in,
  output logic                 mem_write,
  output logic                 cpu_run,
  output logic                 load_err,
  output logic [ADDR_W:0]      words_loaded
);
  if ((WORD_SIZE % 8) != 0) begin : g_bad_word_size
    $error("subleq_loader: WORD_SIZE must be a multiple of 8");
  end

  localparam int WL_W = ADDR_W + 1;

  loader_state_e           r_state;
  logic [LOADER_LEN_W-1:0] r_len;
  logic [LOADER_LEN_W-1:0] r_word_idx;
  logic [7:0]              r_csum;
  logic                    r_in_ready;
  logic                    r_cpu_run;
  logic                    r_load_err;
  logic [WL_W-1:0]         r_words_loaded;
  logic [ADDR_W-1:0]       r_mem_add;

  logic                    w_xfer;
  logic                    w_shift;
  logic                    w_clr;
  logic                    w_last;
  logic                    w_word_done;
  logic [WORD_SIZE-1:0]    w_word;
  logic [LOADER_LEN_W-1:0] w_len_full;

  assign w_xfer     = in_valid & r_in_ready;
  assign w_shift    = w_xfer & (r_state == DATA);
  assign w_clr      = w_xfer & (r_state == LEN1);
  assign w_len_full = {in_data, r_len[7:0]};

  word_packer #(.WORD_SIZE(WORD_SIZE)) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_clr),
    .i_shift     (w_shift),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_done (w_word_done),
    .o_last      (w_last)
  );

  // Frame FSM; in_ready is registered, so it follows the state one cycle after each decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= LEN0;
      r_len          <= '0;
      r_word_idx     <= '0;
      r_csum         <= 8'd0;
      r_in_ready     <= 1'b0;
      r_cpu_run      <= 1'b0;
      r_load_err     <= 1'b0;
      r_words_loaded <= '0;
      r_mem_add      <= '0;
    end else begin
      if (w_word_done) begin
        r_words_loaded <= r_words_loaded + WL_W'(1);
      end
      case (r_state)
        LEN0: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_len[7:0] <= in_data;
            r_state    <= LEN1;
          end
        end
        LEN1: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_len      <= w_len_full;
            r_word_idx <= '0;
            // Full 16-bit compare: a length like 0x0101 must not alias into range.
            if ({16'd0, w_len_full} > 32'(MEM_SIZE)) begin
              r_state    <= ERROR;
              r_load_err <= 1'b1;
              r_in_ready <= 1'b0;
            end else if (w_len_full == '0) begin
              r_state <= CSUM;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_csum <= r_csum ^ in_data;
            if (w_last) begin
              r_mem_add  <= r_word_idx[ADDR_W-1:0];
              r_word_idx <= r_word_idx + LOADER_LEN_W'(1);
              if ((r_word_idx + LOADER_LEN_W'(1)) == r_len) begin
                r_state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_state   <= DONE;
              r_cpu_run <= 1'b1;
            end else begin
              r_state    <= ERROR;
              r_load_err <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          r_in_ready <= 1'b0;
          if (restart) begin
            r_state        <= LEN0;
            r_in_ready     <= 1'b1;
            r_cpu_run      <= 1'b0;
            r_load_err     <= 1'b0;
            r_words_loaded <= '0;
            r_csum         <= 8'd0;
          end
        end
        default: begin
          r_state    <= LEN0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign mem_add      = WORD_SIZE'(r_mem_add);
  assign mem_data_in  = w_word;
  assign mem_write    = w_word_done;
  assign cpu_run      = r_cpu_run;
  assign load_err     = r_load_err;
  assign words_loaded = r_words_loaded;
endmodule

// File: tb/tb_subleq_loader.sv
// Self-checking bench for subleq_loader: frame-level model of expected writes and flags,
// checked every cycle, plus literal expectations for the documented frames.
module tb_subleq_loader;
  localparam int WS = 32;
  localparam int MS = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          restart = 1'b0;
  logic          in_ready;
  logic [WS-1:0] mem_add;
  logic [WS-1:0] mem_data_in;
  logic          mem_write;
  logic          cpu_run;
  logic          load_err;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  subleq_loader #(.WORD_SIZE(WS), .MEM_SIZE(MS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .restart      (restart),
    .mem_add      (mem_add),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_writes = 0;
  int   wl_base = 0;
  int   exp_n = 0;
  bit   chk_en = 1'b0;
  logic exp_run = 1'b0;
  logic exp_err = 1'b0;
  logic exp_rdy = 1'b0;
  logic [31:0] exp_data [0:MS-1];
  logic [31:0] cap_mem  [0:MS-1];
  logic [7:0]  pay_buf  [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare: flags against the model, each write against the expected word list.
  always @(negedge clk) begin
    int k;
    if (chk_en && rst_n) begin
      chk("cpu_run", 32'(cpu_run), 32'(exp_run));
      chk("load_err", 32'(load_err), 32'(exp_err));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("words_loaded", 32'(words_loaded), 32'(n_writes - wl_base));
      if (mem_write) begin
        k = n_writes - wl_base;
        if (k < exp_n) begin
          chk("wr_addr", mem_add, 32'(k));
          chk("wr_data", mem_data_in, exp_data[k]);
        end else begin
          chk("wr_unexpected", 32'(mem_write), 32'd0);
        end
        cap_mem[mem_add[AW-1:0]] = mem_data_in;
        n_writes++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int idle;
    bit done;
    idle = 0;
    done = 1'b0;
    if (gap > 0 && $urandom_range(99, 0) < gap) idle = $urandom_range(3, 1);
    @(negedge clk);
    if (idle > 0) begin
      in_valid = 1'b0;
      repeat (idle) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !done; t++) begin
      if (in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [7:0] csum, input int gap,
                            input int stop_after, input int restart_at);
    int npay;
    logic [7:0] x;
    bit ok_len;
    ok_len = (int'(len) <= MS);
    exp_n  = ok_len ? int'(len) : 0;
    for (int k = 0; k < exp_n; k++) begin
      exp_data[k] = 32'd0;
      for (int j = 0; j < 4; j++) exp_data[k] = exp_data[k] | (32'(pay_buf[(k*4+j) % 16]) << (8*j));
    end
    npay = exp_n * 4;
    x = 8'd0;
    for (int i = 0; i < npay; i++) x = x ^ pay_buf[i % 16];
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    if (!ok_len) begin
      exp_err = 1'b1;
      exp_rdy = 1'b0;
      return;
    end
    for (int i = 0; i < npay; i++) begin
      if (i == stop_after) return;
      if (i == restart_at) begin
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b1;
        @(negedge clk);
        restart  = 1'b0;
      end
      send_byte(pay_buf[i % 16], gap);
    end
    send_byte(csum, gap);
    if (csum == x) exp_run = 1'b1;
    else           exp_err = 1'b1;
    exp_rdy = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_nwrites"}, 32'(n_writes - wl_base), 32'(exp_n));
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_n));
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    exp_run = 1'b0;
    exp_err = 1'b0;
    exp_rdy = 1'b1;
    wl_base = n_writes;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    restart  = 1'b0;
    #1;
    exp_run = 1'b0;
    exp_err = 1'b0;
    exp_rdy = 1'b0;
    exp_n   = 0;
    wl_base = n_writes;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_add", mem_add, 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    exp_rdy = 1'b1;
  endtask

  task automatic clear_cap();
    cap_mem[0] = 32'd0;
    cap_mem[1] = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) pay_buf[i] = 8'(8'h11 * (i + 1));
    for (int i = 8; i < 16; i++) pay_buf[i] = 8'd0;
    clear_cap();

    do_reset();
    chk_en = 1'b1;

    send_frame(16'd2, 8'h88, 0, -1, -1);
    finish_frame("good");
    chk("good_mem0", cap_mem[0], 32'h44332211);
    chk("good_mem1", cap_mem[1], 32'h88776655);
    chk("good_cpu_run", 32'(cpu_run), 32'd1);
    chk("good_wl", 32'(words_loaded), 32'd2);
    pulse_restart();

    clear_cap();
    send_frame(16'd2, 8'h00, 0, -1, -1);
    finish_frame("badsum");
    chk("badsum_mem1", cap_mem[1], 32'h88776655);
    chk("badsum_err", 32'(load_err), 32'd1);
    chk("badsum_run", 32'(cpu_run), 32'd0);
    chk("badsum_rdy", 32'(in_ready), 32'd0);
    pulse_restart();
    @(negedge clk);
    chk("restart_err", 32'(load_err), 32'd0);
    chk("restart_rdy", 32'(in_ready), 32'd1);

    send_frame(16'h0101, 8'h00, 0, -1, -1);
    finish_frame("toolong");
    chk("toolong_err", 32'(load_err), 32'd1);
    pulse_restart();

    send_frame(16'd0, 8'h00, 0, -1, -1);
    finish_frame("empty");
    chk("empty_run", 32'(cpu_run), 32'd1);
    chk("empty_wl", 32'(words_loaded), 32'd0);
    pulse_restart();

    clear_cap();
    send_frame(16'd2, 8'h88, 30, -1, 5);
    finish_frame("gaps");
    chk("gaps_mem0", cap_mem[0], 32'h44332211);
    chk("gaps_mem1", cap_mem[1], 32'h88776655);
    chk("gaps_run", 32'(cpu_run), 32'd1);
    pulse_restart();

    send_frame(16'd2, 8'h88, 0, 6, -1);
    do_reset();
    clear_cap();
    send_frame(16'd2, 8'h88, 0, -1, -1);
    finish_frame("after_rst");
    chk("after_rst_mem0", cap_mem[0], 32'h44332211);
    chk("after_rst_mem1", cap_mem[1], 32'h88776655);
    chk("after_rst_run", 32'(cpu_run), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
